// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detection for a 5-stage core: load-use and branch-in-ID stalls,
// taken-branch/jump flushes, stall/flush performance counters and a stall watchdog.
module hazard_stall_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_RegRs,
  input  logic [4:0]  ID_RegRt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_Rd,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_Rd,
  input  logic        CountClear,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic [1:0]  HazState,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCycles,
  output logic        HazError
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hazState_t;

  hazState_t  state;
  logic [1:0] consecStall;
  logic       exSrcMatch;
  logic       memSrcMatch;
  logic       loadUse;
  logic       brAlu;
  logic       brMemLoad;
  logic       stall;
  logic       flush;

  // r0 is hardwired to zero, so it never creates a dependency; rt only counts when read.
  assign exSrcMatch  = (EX_Rd != 5'd0) &&
                       ((ID_RegRs == EX_Rd) || (ID_UsesRt && (ID_RegRt == EX_Rd)));
  assign memSrcMatch = (MEM_Rd != 5'd0) &&
                       ((ID_RegRs == MEM_Rd) || (ID_UsesRt && (ID_RegRt == MEM_Rd)));

  assign loadUse   = EX_MemRead && exSrcMatch;
  assign brAlu     = ID_Branch && EX_RegWrite && !EX_MemRead && exSrcMatch;
  assign brMemLoad = ID_Branch && MEM_MemRead && memSrcMatch;

  assign stall = loadUse || brAlu || brMemLoad;
  assign flush = !stall && ((ID_Branch && ID_BranchTaken) || ID_Jump);

  // While in reset the pipeline is held frozen with a bubble in ID/EX.
  assign PC_Write    = Rst && !stall;
  assign IFID_Write  = Rst && !stall;
  assign IDEX_Bubble = !Rst || stall;
  assign IFID_Flush  = Rst && flush;

  assign HazState = state;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= RUN;
      consecStall <= 2'd0;
      StallCycles <= 16'd0;
      FlushCycles <= 16'd0;
      HazError    <= 1'b0;
    end else begin
      if (stall)      state <= STALL;
      else if (flush) state <= FLUSH;
      else            state <= RUN;

      if (!stall)                    consecStall <= 2'd0;
      else if (consecStall != 2'd3)  consecStall <= consecStall + 2'd1;

      // Third back-to-back stall means something upstream is wedged; sticky until reset.
      if (stall && (consecStall == 2'd2)) HazError <= 1'b1;

      if (CountClear) begin
        StallCycles <= 16'd0;
        FlushCycles <= 16'd0;
      end else begin
        if (stall && (StallCycles != 16'hFFFF)) StallCycles <= StallCycles + 16'd1;
        if (flush && (FlushCycles != 16'hFFFF)) FlushCycles <= FlushCycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a table of single-cycle hazard vectors
// followed by hand-written multi-cycle sequences for the corner cases.
module tb_hazard_stall_unit;

  logic        Clk;
  logic        Rst;
  logic [4:0]  ID_RegRs;
  logic [4:0]  ID_RegRt;
  logic        ID_UsesRt;
  logic        ID_Branch;
  logic        ID_BranchTaken;
  logic        ID_Jump;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_Rd;
  logic        MEM_MemRead;
  logic [4:0]  MEM_Rd;
  logic        CountClear;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IDEX_Bubble;
  logic        IFID_Flush;
  logic [1:0]  HazState;
  logic [15:0] StallCycles;
  logic [15:0] FlushCycles;
  logic        HazError;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_STALL = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;

  hazard_stall_unit dut (
    .Clk(Clk), .Rst(Rst),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .CountClear(CountClear),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .HazState(HazState), .StallCycles(StallCycles),
    .FlushCycles(FlushCycles), .HazError(HazError)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       branch;
    logic       taken;
    logic       jump;
    logic       exMemRead;
    logic       exRegWrite;
    logic [4:0] exRd;
    logic       memMemRead;
    logic [4:0] memRd;
    logic       expStall;
    logic       expFlush;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkVec(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic branch, input logic taken, input logic jump,
                                 input logic exMemRead, input logic exRegWrite, input logic [4:0] exRd,
                                 input logic memMemRead, input logic [4:0] memRd,
                                 input logic expStall, input logic expFlush);
    vec_t v;
    v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.branch = branch; v.taken = taken;
    v.jump = jump; v.exMemRead = exMemRead; v.exRegWrite = exRegWrite; v.exRd = exRd;
    v.memMemRead = memMemRead; v.memRd = memRd; v.expStall = expStall; v.expFlush = expFlush;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    ID_RegRs = 5'd0; ID_RegRt = 5'd0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
    ID_BranchTaken = 1'b0; ID_Jump = 1'b0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    EX_Rd = 5'd0; MEM_MemRead = 1'b0; MEM_Rd = 5'd0; CountClear = 1'b0;
  endtask

  task automatic applyVec(input vec_t v);
    ID_RegRs = v.rs; ID_RegRt = v.rt; ID_UsesRt = v.usesRt; ID_Branch = v.branch;
    ID_BranchTaken = v.taken; ID_Jump = v.jump; EX_MemRead = v.exMemRead;
    EX_RegWrite = v.exRegWrite; EX_Rd = v.exRd; MEM_MemRead = v.memMemRead; MEM_Rd = v.memRd;
  endtask

  task automatic loadUse(input logic [4:0] r);
    idleInputs();
    EX_MemRead = 1'b1; EX_Rd = r; ID_RegRs = r;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkCtl(input string name, input logic expStall, input logic expFlush);
    check({name, ".PC_Write"},    PC_Write,    !expStall);
    check({name, ".IFID_Write"},  IFID_Write,  !expStall);
    check({name, ".IDEX_Bubble"}, IDEX_Bubble, expStall);
    check({name, ".IFID_Flush"},  IFID_Flush,  expFlush);
  endtask

  int expStallCnt;
  int expFlushCnt;

  initial begin
    idleInputs();
    Rst = 1'b0;

    // Reset state
    #2;
    checkCtl("reset", 1'b1, 1'b0);
    check("reset.HazState", HazState, S_RUN);
    check("reset.StallCycles", StallCycles, 16'd0);
    check("reset.FlushCycles", FlushCycles, 16'd0);
    check("reset.HazError", HazError, 1'b0);
    tick(); tick();
    Rst = 1'b1;
    tick();

    //          rs  rt  uRt br tk jp exMR exRW exRd memMR memRd  stall flush
    vecs[0]  = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    vecs[1]  = mkVec(5'd5, 5'd0, 0, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0, 1, 0);
    vecs[2]  = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0, 0, 0);
    vecs[3]  = mkVec(5'd1, 5'd9, 0, 0, 0, 0, 1, 1, 5'd9, 0, 5'd0, 0, 0);
    vecs[4]  = mkVec(5'd1, 5'd9, 1, 0, 0, 0, 1, 1, 5'd9, 0, 5'd0, 1, 0);
    vecs[5]  = mkVec(5'd3, 5'd0, 0, 1, 1, 0, 0, 1, 5'd3, 0, 5'd0, 1, 0);
    vecs[6]  = mkVec(5'd3, 5'd0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 5'd0, 0, 0);
    vecs[7]  = mkVec(5'd4, 5'd0, 0, 1, 1, 0, 0, 1, 5'd3, 0, 5'd0, 0, 1);
    vecs[8]  = mkVec(5'd4, 5'd0, 0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    vecs[9]  = mkVec(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 1);
    vecs[10] = mkVec(5'd2, 5'd0, 0, 0, 0, 1, 1, 1, 5'd2, 0, 5'd0, 1, 0);
    vecs[11] = mkVec(5'd1, 5'd7, 1, 1, 0, 0, 0, 0, 5'd0, 1, 5'd7, 1, 0);
    vecs[12] = mkVec(5'd7, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 1, 5'd7, 0, 0);
    vecs[13] = mkVec(5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 5'd0, 1, 5'd0, 0, 0);
    vecs[14] = mkVec(5'd6, 5'd0, 0, 1, 1, 0, 1, 1, 5'd6, 0, 5'd0, 1, 0);

    expStallCnt = 0;
    expFlushCnt = 0;
    for (int i = 0; i < 15; i++) begin
      applyVec(vecs[i]);
      #1;
      checkCtl($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expFlush);
      if (vecs[i].expStall) expStallCnt++;
      if (vecs[i].expFlush) expFlushCnt++;
      tick();
      check($sformatf("vec%0d.HazState", i), HazState,
            vecs[i].expStall ? S_STALL : (vecs[i].expFlush ? S_FLUSH : S_RUN));
    end
    check("table.StallCycles", StallCycles, expStallCnt);
    check("table.FlushCycles", FlushCycles, expFlushCnt);
    check("table.HazError", HazError, 1'b0);

    // Branch on a load: two stalls, then the taken branch flushes
    idleInputs();
    CountClear = 1'b1;
    tick();
    CountClear = 1'b0;
    check("clr.StallCycles", StallCycles, 16'd0);
    check("clr.FlushCycles", FlushCycles, 16'd0);
    ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_RegRs = 5'd8;
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd8;
    #1;
    checkCtl("brld.c1", 1'b1, 1'b0);
    tick();
    check("brld.c1.HazState", HazState, S_STALL);
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_Rd = 5'd0;
    MEM_MemRead = 1'b1; MEM_Rd = 5'd8;
    #1;
    checkCtl("brld.c2", 1'b1, 1'b0);
    tick();
    MEM_MemRead = 1'b0; MEM_Rd = 5'd0;
    #1;
    checkCtl("brld.c3", 1'b0, 1'b1);
    tick();
    check("brld.HazState", HazState, S_FLUSH);
    check("brld.StallCycles", StallCycles, 16'd2);
    check("brld.FlushCycles", FlushCycles, 16'd1);
    check("brld.HazError", HazError, 1'b0);

    // Jump alongside load-use: stall wins, jump flushes once the hazard clears
    loadUse(5'd11);
    ID_Jump = 1'b1;
    #1;
    checkCtl("jmp.hazard", 1'b1, 1'b0);
    tick();
    EX_MemRead = 1'b0; EX_Rd = 5'd0;
    #1;
    checkCtl("jmp.clear", 1'b0, 1'b1);
    tick();
    check("jmp.HazState", HazState, S_FLUSH);

    // Watchdog: third consecutive stall sets the sticky error
    idleInputs();
    tick();
    loadUse(5'd12);
    tick();
    check("wd.edge1.HazError", HazError, 1'b0);
    tick();
    check("wd.edge2.HazError", HazError, 1'b0);
    tick();
    check("wd.edge3.HazError", HazError, 1'b1);
    idleInputs();
    tick(); tick();
    check("wd.sticky.HazError", HazError, 1'b1);

    // Reset in the middle of a stall run
    loadUse(5'd13);
    tick(); tick();
    Rst = 1'b0;
    #1;
    check("rstmid.HazError", HazError, 1'b0);
    check("rstmid.HazState", HazState, S_RUN);
    check("rstmid.StallCycles", StallCycles, 16'd0);
    checkCtl("rstmid", 1'b1, 1'b0);
    idleInputs();
    tick();
    Rst = 1'b1;
    #1;
    checkCtl("rstrel", 1'b0, 1'b0);
    tick();
    check("rstrel.HazState", HazState, S_RUN);
    loadUse(5'd14);
    tick(); tick();
    check("fresh.HazError", HazError, 1'b0);
    check("fresh.StallCycles", StallCycles, 16'd2);

    // Stall counter saturation and clear priority
    idleInputs();
    CountClear = 1'b1;
    tick();
    loadUse(5'd15);
    for (int i = 0; i < 65535; i++) @(posedge Clk);
    #1;
    check("sat.StallCycles", StallCycles, 16'hFFFF);
    tick();
    check("sat.hold.StallCycles", StallCycles, 16'hFFFF);
    CountClear = 1'b1;
    tick();
    check("clrstall.StallCycles", StallCycles, 16'd0);
    check("clrstall.HazState", HazState, S_STALL);
    check("clrstall.HazError", HazError, 1'b1);
    idleInputs();
    tick();

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
